data_sram_responder: RTL

- Slave/responder end of the pipeline's SRAM-like data interface: accepts load/store requests from the EXE-side issue logic and returns in-order data_ok/rdata, which the MEM stage consumes.
- Backed by a word-addressed internal memory, with fixed configurable response latency and a bounded number of outstanding transactions.
- Used as the data-side memory model in core-level simulation and as the template for the later AXI bridge read/write channel split.

---
 rtl/data_sram_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: word memory plus an in-order, fixed-latency response queue.
// Loads capture their word when accepted; stores respond with zero data.
module data_sram_responder #(
  parameter int unsigned AW      = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  input  logic        stall_in,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  outstanding
);

  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C  = 4'(DEPTH);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  logic [31:0]      r_mem [1 << AW];
  logic [31:0]      r_q_data [DEPTH];
  logic [2:0]       r_q_cnt [DEPTH];
  logic [DEPTH-1:0] r_q_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [3:0]       r_count;
  logic             r_data_ok;
  logic [31:0]      r_rdata;

  logic [AW-1:0]    w_idx;
  logic             w_addr_ok;
  logic             w_accept;
  logic             w_pop;
  logic [31:0]      w_push_data;
  logic             w_unused;

  assign w_idx       = data_sram_addr[AW+1:2];
  assign w_addr_ok   = resetn & data_sram_req & ~stall_in & (r_count < DEPTH_C);
  assign w_accept    = data_sram_req & w_addr_ok;
  assign w_pop       = r_q_vld[r_rd_ptr] & (r_q_cnt[r_rd_ptr] == 3'd0);
  assign w_push_data = data_sram_wr ? '0 : r_mem[w_idx];
  assign w_unused    = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  // Memory is deliberately left out of reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (w_accept && data_sram_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_q_vld   <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_q_vld[i] && (r_q_cnt[i] != 3'd0)) begin
          r_q_cnt[i] <= r_q_cnt[i] - 3'd1;
        end
      end
      r_data_ok <= w_pop;
      if (w_pop) begin
        r_rdata           <= r_q_data[r_rd_ptr];
        r_q_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      // Acceptance requires a free slot, so the write slot never collides with the popped head.
      if (w_accept) begin
        r_q_data[r_wr_ptr] <= w_push_data;
        r_q_cnt[r_wr_ptr]  <= CNT_INIT;
        r_q_vld[r_wr_ptr]  <= 1'b1;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_sram_addr_ok = w_addr_ok;
  assign data_sram_data_ok = r_data_ok;
  assign data_sram_rdata   = r_rdata;
  assign outstanding       = r_count;

endmodule
